multi_bank_switch: RTL and testbench

MULTI_BANK_SWITCH -- requirements
Module: multi_bank_switch

---
 rtl/multi_bank_switch_if.sv | 27 ++
 rtl/multi_bank_switch.sv | 135 +++++++++++++
 tb/tb_multi_bank_switch.sv | 208 ++++++++++++++++++++
 3 files changed

// File: rtl/multi_bank_switch_if.sv
// Camera/DDR frame-bank switch interface: frame-event inputs toward the switch, bank selects and pulses back.
// master = the frame source/sink side driving events; slave = the bank switch.
interface multi_bank_switch_if #(
    parameter int BANK_W = 2
);
    logic              bank_valid;
    logic              frame_write_done;
    logic              frame_read_done;
    logic              data_valid;
    logic [BANK_W-1:0] wr_bank;
    logic [BANK_W-1:0] rd_bank;
    logic              wr_load;
    logic              rd_load;
    logic              frame_drop;
    logic              repeat_frame;
    logic [7:0]        drop_cnt;

    modport master (
        output bank_valid, frame_write_done, frame_read_done, data_valid,
        input  wr_bank, rd_bank, wr_load, rd_load, frame_drop, repeat_frame, drop_cnt
    );

    modport slave (
        input  bank_valid, frame_write_done, frame_read_done, data_valid,
        output wr_bank, rd_bank, wr_load, rd_load, frame_drop, repeat_frame, drop_cnt
    );
endinterface

// File: rtl/multi_bank_switch.sv
// Rotates writer/reader DDR frame banks; all outputs registered, bank changes land on the commit/exit edge.
// No backpressure: the writer overwrites an unread frame (frame_drop) and the reader repeats when nothing new is ready.
module multi_bank_switch #(
    parameter int BANK_NUM = 3,
    parameter int BANK_W   = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    multi_bank_switch_if.slave sw
);
    typedef enum logic [2:0] {
        LOAD0     = 3'd0,
        LOAD1     = 3'd1,
        LOAD2     = 3'd2,
        WAIT_EDGE = 3'd3,
        WAIT_DONE = 3'd4
    } st_e;

    st_e               wr_st_q, wr_st_d, rd_st_q, rd_st_d;
    logic              sync1_q, sync2_q, edge_flag;
    logic [BANK_W-1:0] wr_bank_q, wr_bank_d, rd_bank_q, rd_bank_d, latest_q, latest_d;
    logic              fresh_q, fresh_d;
    logic              wr_load_q, wr_load_d, rd_load_q, rd_load_d;
    logic              drop_q, drop_d, repeat_q, repeat_d;
    logic [7:0]        drop_cnt_q, drop_cnt_d;
    logic              wr_commit, rd_exit, rd_take;
    logic [BANK_W-1:0] rd_bank_nxt, wr_bank_pick, cand;
    logic [BANK_W:0]   cand_sum;
    logic              found;

    assign edge_flag = sync2_q & ~sync1_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_st_q    <= LOAD0;
            rd_st_q    <= LOAD0;
            sync1_q    <= 1'b0;
            sync2_q    <= 1'b0;
            wr_bank_q  <= '0;
            rd_bank_q  <= BANK_W'(BANK_NUM - 1);
            latest_q   <= BANK_W'(BANK_NUM - 1);
            fresh_q    <= 1'b0;
            wr_load_q  <= 1'b0;
            rd_load_q  <= 1'b0;
            drop_q     <= 1'b0;
            repeat_q   <= 1'b0;
            drop_cnt_q <= '0;
        end else begin
            wr_st_q    <= wr_st_d;
            rd_st_q    <= rd_st_d;
            sync1_q    <= sw.bank_valid;
            sync2_q    <= sync1_q;
            wr_bank_q  <= wr_bank_d;
            rd_bank_q  <= rd_bank_d;
            latest_q   <= latest_d;
            fresh_q    <= fresh_d;
            wr_load_q  <= wr_load_d;
            rd_load_q  <= rd_load_d;
            drop_q     <= drop_d;
            repeat_q   <= repeat_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    always_comb begin
        wr_st_d = LOAD0;
        case (wr_st_q)
            LOAD0:     wr_st_d = LOAD1;
            LOAD1:     wr_st_d = LOAD2;
            LOAD2:     wr_st_d = WAIT_EDGE;
            WAIT_EDGE: wr_st_d = edge_flag ? WAIT_DONE : WAIT_EDGE;
            WAIT_DONE: wr_st_d = sw.frame_write_done ? LOAD0 : WAIT_DONE;
            default:   wr_st_d = LOAD0;
        endcase
    end

    always_comb begin
        rd_st_d = LOAD0;
        case (rd_st_q)
            LOAD0:     rd_st_d = LOAD1;
            LOAD1:     rd_st_d = LOAD2;
            LOAD2:     rd_st_d = WAIT_EDGE;
            WAIT_EDGE: rd_st_d = edge_flag ? WAIT_DONE : WAIT_EDGE;
            WAIT_DONE: rd_st_d = (sw.frame_read_done && !sw.data_valid) ? LOAD0 : WAIT_DONE;
            default:   rd_st_d = LOAD0;
        endcase
    end

    // Load pulses are registered from the next state so they coincide with LOAD2.
    always_comb begin
        wr_load_d = (wr_st_d == LOAD2);
        rd_load_d = (rd_st_d == LOAD2);
        wr_commit = (wr_st_q == WAIT_DONE) && sw.frame_write_done;
        rd_exit   = (rd_st_q == WAIT_DONE) && sw.frame_read_done && !sw.data_valid;
    end

    // A same-edge read takeover happens first, so the writer avoids the reader's new bank.
    assign rd_take     = rd_exit & fresh_q;
    assign rd_bank_nxt = rd_take ? latest_q : rd_bank_q;

    always_comb begin
        wr_bank_pick = wr_bank_q;
        found        = 1'b0;
        cand_sum     = '0;
        cand         = '0;
        for (int k = 1; k <= BANK_NUM; k++) begin
            cand_sum = {1'b0, wr_bank_q} + (BANK_W+1)'(k);
            if (cand_sum >= (BANK_W+1)'(BANK_NUM))
                cand_sum = cand_sum - (BANK_W+1)'(BANK_NUM);
            cand = cand_sum[BANK_W-1:0];
            if (!found && (cand != rd_bank_nxt) && ((BANK_NUM < 3) || (cand != wr_bank_q))) begin
                wr_bank_pick = cand;
                found        = 1'b1;
            end
        end
    end

    always_comb begin
        rd_bank_d  = rd_bank_nxt;
        wr_bank_d  = wr_commit ? wr_bank_pick : wr_bank_q;
        latest_d   = wr_commit ? wr_bank_q : latest_q;
        fresh_d    = wr_commit ? 1'b1 : (rd_take ? 1'b0 : fresh_q);
        drop_d     = wr_commit & fresh_q & ~rd_take;
        repeat_d   = rd_exit & ~fresh_q;
        drop_cnt_d = (drop_d && (drop_cnt_q != 8'hFF)) ? drop_cnt_q + 8'd1 : drop_cnt_q;
    end

    assign sw.wr_bank      = wr_bank_q;
    assign sw.rd_bank      = rd_bank_q;
    assign sw.wr_load      = wr_load_q;
    assign sw.rd_load      = rd_load_q;
    assign sw.frame_drop   = drop_q;
    assign sw.repeat_frame = repeat_q;
    assign sw.drop_cnt     = drop_cnt_q;
endmodule

// File: tb/tb_multi_bank_switch.sv
// Randomized scoreboard bench for multi_bank_switch (3-bank main instance) plus a directed 2-bank instance.
module tb_multi_bank_switch;
    logic clk = 1'b0;
    logic rst_n, rst2_n;
    always #5 clk = ~clk;

    multi_bank_switch_if #(.BANK_W(2)) sw();
    multi_bank_switch_if #(.BANK_W(1)) sw2();

    multi_bank_switch #(.BANK_NUM(3), .BANK_W(2)) u_dut  (.clk(clk), .rst_n(rst_n),  .sw(sw));
    multi_bank_switch #(.BANK_NUM(2), .BANK_W(1)) u_dut2 (.clk(clk), .rst_n(rst2_n), .sw(sw2));

    int pass_cnt  = 0;
    int total_cnt = 0;
    int exp_wr_q[$], exp_rd_q[$], exp_rep_q[$], exp_drop_q[$];
    int rd_evt_cnt = 0;

    // Reference model: banks as plain integers, frames handled as whole transactions.
    int m_wr, m_rd, m_latest, m_fresh, m_drops;

    task automatic check(input string name, input int act, input int exp);
        total_cnt++;
        if (act == exp) pass_cnt++;
        else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    endtask

    // With three banks the writer always lands on the one bank nobody else holds.
    function automatic int free_bank(input int a, input int b);
        return 3 - a - b;
    endfunction

    always @(negedge clk) begin
        if (sw.wr_load) begin
            if (exp_wr_q.size() == 0) check("unexpected_wr_load", 1, 0);
            else check("wr_bank_at_wr_load", int'(sw.wr_bank), exp_wr_q.pop_front());
        end
        if (sw.rd_load) begin
            rd_evt_cnt++;
            if (exp_rd_q.size() == 0) check("unexpected_rd_load", 1, 0);
            else check("rd_bank_at_rd_load", int'(sw.rd_bank), exp_rd_q.pop_front());
        end
        if (sw.repeat_frame) begin
            rd_evt_cnt++;
            if (exp_rep_q.size() == 0) check("unexpected_repeat_frame", 1, 0);
            else check("rd_bank_at_repeat", int'(sw.rd_bank), exp_rep_q.pop_front());
        end
        if (sw.frame_drop) begin
            if (exp_drop_q.size() == 0) check("unexpected_frame_drop", 1, 0);
            else check("drop_cnt_at_drop", int'(sw.drop_cnt), exp_drop_q.pop_front());
        end
    end

    task automatic do_edge();
        @(negedge clk) sw.bank_valid = 1'b1;
        repeat (3) @(negedge clk);
        sw.bank_valid = 1'b0;
        repeat (6) @(negedge clk);
    endtask

    task automatic model_write();
        if (m_fresh != 0) begin
            m_drops = (m_drops < 255) ? m_drops + 1 : 255;
            exp_drop_q.push_back(m_drops);
        end
        m_latest = m_wr;
        m_fresh  = 1;
        m_wr     = free_bank(m_wr, m_rd);
        exp_wr_q.push_back(m_wr);
    endtask

    task automatic model_read();
        if (m_fresh != 0) begin
            m_rd    = m_latest;
            m_fresh = 0;
        end else begin
            exp_rep_q.push_back(m_rd);
        end
        exp_rd_q.push_back(m_rd);
    endtask

    task automatic op_write();
        @(negedge clk) sw.frame_write_done = 1'b1;
        model_write();
        @(negedge clk) sw.frame_write_done = 1'b0;
    endtask

    task automatic op_read(input int hold);
        int cnt0;
        @(negedge clk);
        sw.frame_read_done = 1'b1;
        sw.data_valid      = (hold > 0);
        cnt0 = rd_evt_cnt;
        if (hold > 0) begin
            repeat (hold) @(negedge clk);
            check("no_read_exit_while_data_valid", rd_evt_cnt - cnt0, 0);
            sw.data_valid = 1'b0;
        end
        model_read();
        @(negedge clk) sw.frame_read_done = 1'b0;
    endtask

    task automatic op_both();
        @(negedge clk);
        sw.frame_write_done = 1'b1;
        sw.frame_read_done  = 1'b1;
        model_read();
        model_write_after_read();
        @(negedge clk);
        sw.frame_write_done = 1'b0;
        sw.frame_read_done  = 1'b0;
    endtask

    // Simultaneous commit: the reader's takeover means the old fresh frame is never counted as dropped.
    task automatic model_write_after_read();
        m_latest = m_wr;
        m_fresh  = 1;
        m_wr     = free_bank(m_wr, m_rd);
        exp_wr_q.push_back(m_wr);
    endtask

    task automatic round(input int op);
        case (op)
            0:       op_write();
            1:       op_read(0);
            2:       op_both();
            default: op_read(5);
        endcase
        repeat (5) @(negedge clk);
        do_edge();
    endtask

    initial begin
        rst_n  = 1'b0;
        rst2_n = 1'b0;
        sw.bank_valid = 1'b0; sw.frame_write_done = 1'b0; sw.frame_read_done = 1'b0; sw.data_valid = 1'b0;
        sw2.bank_valid = 1'b0; sw2.frame_write_done = 1'b0; sw2.frame_read_done = 1'b0; sw2.data_valid = 1'b0;
        m_wr = 0; m_rd = 2; m_latest = 2; m_fresh = 0; m_drops = 0;
        exp_wr_q.push_back(0);
        exp_rd_q.push_back(2);
        repeat (3) @(negedge clk);
        check("reset_wr_bank", int'(sw.wr_bank), 0);
        check("reset_rd_bank", int'(sw.rd_bank), 2);
        check("reset_drop_cnt", int'(sw.drop_cnt), 0);
        check("reset_loads", int'({sw.wr_load, sw.rd_load, sw.frame_drop, sw.repeat_frame}), 0);

        rst_n = 1'b1;
        @(negedge clk);
        check("wr_load_cycle1", int'(sw.wr_load), 0);
        @(negedge clk);
        check("wr_load_cycle2", int'(sw.wr_load), 1);
        check("rd_load_cycle2", int'(sw.rd_load), 1);
        @(negedge clk);
        check("wr_load_cycle3", int'(sw.wr_load), 0);
        check("rd_load_cycle3", int'(sw.rd_load), 0);
        repeat (3) @(negedge clk);
        do_edge();

        // Directed opening: commit, read takeover, repeat, then the simultaneous case.
        round(0);
        round(1);
        round(3);
        round(0);
        round(2);
        for (int i = 0; i < 80; i++) round(int'($urandom_range(0, 3)));
        for (int i = 0; i < 300; i++) round(0);
        repeat (10) @(negedge clk);
        check("drop_cnt_vs_model", int'(sw.drop_cnt), m_drops);
        check("drop_cnt_saturated", int'(sw.drop_cnt), 255);
        check("wr_queue_drained", exp_wr_q.size(), 0);
        check("rd_queue_drained", exp_rd_q.size(), 0);
        check("repeat_queue_drained", exp_rep_q.size(), 0);
        check("drop_queue_drained", exp_drop_q.size(), 0);

        // Two-bank instance: writer may stay on its own bank; reset mid-frame clears everything.
        rst2_n = 1'b1;
        repeat (6) @(negedge clk);
        for (int w = 0; w < 2; w++) begin
            sw2.bank_valid = 1'b1;
            repeat (3) @(negedge clk);
            sw2.bank_valid = 1'b0;
            repeat (6) @(negedge clk);
            sw2.frame_write_done = 1'b1;
            @(negedge clk) sw2.frame_write_done = 1'b0;
            repeat (6) @(negedge clk);
            check("b2_wr_bank_after_commit", int'(sw2.wr_bank), 0);
            check("b2_rd_bank_after_commit", int'(sw2.rd_bank), 1);
            check("b2_drop_cnt_after_commit", int'(sw2.drop_cnt), w);
        end
        sw2.bank_valid = 1'b1;
        repeat (3) @(negedge clk);
        sw2.bank_valid = 1'b0;
        repeat (6) @(negedge clk);
        #2 rst2_n = 1'b0;
        #1;
        check("b2_async_reset_drop_cnt", int'(sw2.drop_cnt), 0);
        check("b2_async_reset_banks", int'({sw2.wr_bank, sw2.rd_bank}), 1);
        check("b2_async_reset_pulses", int'({sw2.wr_load, sw2.rd_load, sw2.frame_drop, sw2.repeat_frame}), 0);
        @(negedge clk) rst2_n = 1'b1;
        @(negedge clk);
        check("b2_wr_load_after_rerelease_c1", int'(sw2.wr_load), 0);
        @(negedge clk);
        check("b2_wr_load_after_rerelease_c2", int'(sw2.wr_load), 1);
        check("b2_rd_load_after_rerelease_c2", int'(sw2.rd_load), 1);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
